// File: rtl/psum_row_collector_pkg.sv
// psum_row_collector_pkg
//   Shared constants for the MAC column array, the psum row collector and the
//   SFU, so all three agree on lane count, psum width and FIFO depth.
//   Also provides the helper that locates lane j inside a concatenated row.
package psum_row_collector_pkg;

  localparam int COL     = 8;   // number of MAC columns (lanes)
  localparam int BW_PSUM = 14;  // width of one column psum (2*bw+6, bw=4)
  localparam int DEPTH   = 16;  // entries per lane FIFO, power of two
  localparam int AW      = 4;   // log2(DEPTH)

  localparam int ROW_W   = COL * BW_PSUM;

  // Lowest bit index of lane j in a concatenated row (lane 0 at the LSBs).
  function automatic int lane_lo(input int j);
    return j * BW_PSUM;
  endfunction

endpackage

// File: rtl/psum_row_collector_if.sv
// psum_row_collector_if
//   Bundle between the column array / downstream reader and the collector.
//   wr         per-column write strobes (bit j = column j fifo_wr)
//   in         concatenated column psums, lane j at lane_lo(j)
//   rd         pop request from the reader
//   out        head row, same lane order as in
//   o_valid    every lane holds at least one entry
//   o_full     at least one lane is full
//   o_empty    every lane is empty
//   o_overflow sticky: a write was dropped on a full lane
//   Modport slave is the collector, master is the side driving it.
interface psum_row_collector_if;
  import psum_row_collector_pkg::*;

  logic [COL-1:0]   wr;
  logic [ROW_W-1:0] in;
  logic             rd;
  logic [ROW_W-1:0] out;
  logic             o_valid;
  logic             o_full;
  logic             o_empty;
  logic             o_overflow;

  modport slave (
    input  wr, in, rd,
    output out, o_valid, o_full, o_empty, o_overflow
  );

  modport master (
    output wr, in, rd,
    input  out, o_valid, o_full, o_empty, o_overflow
  );
endinterface

// File: rtl/psum_row_collector_lane_fifo.sv
// psum_lane_fifo
//   One lane of the row collector: a first-word fall-through FIFO.
//   Ports:
//     clk    rising-edge clock
//     reset  synchronous active-low reset (pointers and count only)
//     wr     write request for this lane
//     din    psum to store (kept bit-exact)
//     pop    advance the read pointer (caller guarantees lane non-empty)
//     dout   entry at the read pointer, 0 while the lane is empty
//     empty  count == 0
//     full   count == DEPTH
//     drop   this cycle's write is being discarded (full, no pop)
module psum_lane_fifo #(
  parameter int BW_PSUM = 14,
  parameter int DEPTH   = 16,
  parameter int AW      = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               wr,
  input  logic [BW_PSUM-1:0] din,
  input  logic               pop,
  output logic [BW_PSUM-1:0] dout,
  output logic               empty,
  output logic               full,
  output logic               drop
);

  logic [BW_PSUM-1:0] r_mem [DEPTH];
  logic [AW-1:0]      r_wptr;
  logic [AW-1:0]      r_rptr;
  logic [AW:0]        r_count;
  logic               w_push;

  assign empty = (r_count == '0);
  assign full  = (r_count == (AW+1)'(DEPTH));

  // A full lane still accepts a write when it is popped in the same cycle,
  // because the pop frees the slot the write lands in.
  assign w_push = wr && (!full || pop);
  assign drop   = wr && full && !pop;

  // Pointers wrap naturally since DEPTH == 2**AW.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (pop)    r_rptr <= r_rptr + 1'b1;
      case ({w_push, pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage is never cleared; stale entries are hidden by the empty mask.
  always_ff @(posedge clk) begin
    if (reset && w_push) r_mem[r_wptr] <= din;
  end

  assign dout = empty ? '0 : r_mem[r_rptr];

endmodule

// File: rtl/psum_row_collector.sv
// psum_row_collector
//   Captures each MAC column's psum into its own lane FIFO and presents
//   complete rows to the downstream reader. Column strobes arrive staggered
//   one cycle per column; lanes fill independently, so a row simply becomes
//   available once the last lane has its entry.
//   Ports:
//     clk    rising-edge clock
//     reset  synchronous active-low reset
//     bus    psum_row_collector_if.slave (wr/in/rd in, row and flags out)
module psum_row_collector
  import psum_row_collector_pkg::*;
(
  input  logic                  clk,
  input  logic                  reset,
  psum_row_collector_if.slave   bus
);

  logic [COL-1:0]     w_empty;
  logic [COL-1:0]     w_full;
  logic [COL-1:0]     w_drop;
  logic [BW_PSUM-1:0] w_dout [COL];
  logic [ROW_W-1:0]   w_out;
  logic               w_valid;
  logic               w_pop;
  logic               r_overflow;

  assign w_valid = &(~w_empty);
  // A row pop moves every lane together, and only when a full row exists.
  assign w_pop   = bus.rd && w_valid;

  generate
    for (genvar gi = 0; gi < COL; gi++) begin : g_lane
      psum_lane_fifo #(
        .BW_PSUM (BW_PSUM),
        .DEPTH   (DEPTH),
        .AW      (AW)
      ) u_lane (
        .clk   (clk),
        .reset (reset),
        .wr    (bus.wr[gi]),
        .din   (bus.in[lane_lo(gi) +: BW_PSUM]),
        .pop   (w_pop),
        .dout  (w_dout[gi]),
        .empty (w_empty[gi]),
        .full  (w_full[gi]),
        .drop  (w_drop[gi])
      );
    end
  endgenerate

  always_comb begin
    w_out = '0;
    for (int j = 0; j < COL; j++) begin
      w_out[lane_lo(j) +: BW_PSUM] = w_dout[j];
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_overflow <= 1'b0;
    end else if (|w_drop) begin
      r_overflow <= 1'b1;
    end
  end

  assign bus.out        = w_out;
  assign bus.o_valid    = w_valid;
  assign bus.o_empty    = &w_empty;
  assign bus.o_full     = |w_full;
  assign bus.o_overflow = r_overflow;

endmodule

// File: tb/tb_psum_row_collector.sv
// Bench for psum_row_collector: directed scenarios followed by randomized
// traffic, every cycle compared against a queue-based row model, plus
// literal expectations for the directed scenarios.
module tb_psum_row_collector;
  import psum_row_collector_pkg::*;

  logic clk;
  logic reset;

  psum_row_collector_if bus ();

  psum_row_collector dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_total;
  int n_pass;

  // Model: one queue per lane holding the accepted psums in order.
  logic [BW_PSUM-1:0] mq [COL][$];
  logic               m_ovf;

  task automatic check(input string name, input logic [ROW_W-1:0] act,
                       input logic [ROW_W-1:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  // Apply one clock edge of inputs to the model.
  task automatic model_edge();
    bit all_ne;
    bit do_pop;
    if (!reset) begin
      for (int j = 0; j < COL; j++) mq[j].delete();
      m_ovf = 1'b0;
    end else begin
      all_ne = 1'b1;
      for (int j = 0; j < COL; j++) if (mq[j].size() == 0) all_ne = 1'b0;
      do_pop = bus.rd && all_ne;
      for (int j = 0; j < COL; j++) begin
        bit was_full;
        was_full = (mq[j].size() == DEPTH);
        if (do_pop) void'(mq[j].pop_front());
        if (bus.wr[j]) begin
          if (!was_full || do_pop) mq[j].push_back(bus.in[lane_lo(j) +: BW_PSUM]);
          else m_ovf = 1'b1;
        end
      end
    end
  endtask

  task automatic compare_model();
    logic [ROW_W-1:0] e_out;
    bit e_valid, e_empty, e_full;
    e_out = '0;
    e_valid = 1'b1;
    e_empty = 1'b1;
    e_full = 1'b0;
    for (int j = 0; j < COL; j++) begin
      if (mq[j].size() != 0) begin
        e_out[lane_lo(j) +: BW_PSUM] = mq[j][0];
        e_empty = 1'b0;
      end else begin
        e_valid = 1'b0;
      end
      if (mq[j].size() == DEPTH) e_full = 1'b1;
    end
    check("out",        bus.out,                 e_out);
    check("o_valid",    ROW_W'(bus.o_valid),     ROW_W'(e_valid));
    check("o_empty",    ROW_W'(bus.o_empty),     ROW_W'(e_empty));
    check("o_full",     ROW_W'(bus.o_full),      ROW_W'(e_full));
    check("o_overflow", ROW_W'(bus.o_overflow),  ROW_W'(m_ovf));
  endtask

  // One cycle: inputs already set; model follows the edge, outputs checked 1 after.
  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    compare_model();
  endtask

  task automatic idle();
    bus.wr = '0;
    bus.rd = 1'b0;
    bus.in = '0;
  endtask

  task automatic do_reset();
    idle();
    reset = 1'b0;
    step();
    reset = 1'b1;
  endtask

  function automatic logic [ROW_W-1:0] rand_row();
    logic [127:0] t;
    t = {$urandom, $urandom, $urandom, $urandom};
    return t[ROW_W-1:0];
  endfunction

  task automatic lit(input string name, input logic act, input logic exp);
    check(name, ROW_W'(act), ROW_W'(exp));
  endtask

  initial begin
    logic [ROW_W-1:0] row;
    n_total = 0;
    n_pass = 0;
    m_ovf = 1'b0;
    reset = 1'b0;
    idle();

    // Reset state.
    step();
    step();
    reset = 1'b1;
    lit("rst_valid", bus.o_valid, 1'b0);
    lit("rst_empty", bus.o_empty, 1'b1);
    lit("rst_full",  bus.o_full,  1'b0);
    check("rst_out", bus.out, '0);

    // Staggered single row: lane j = j+1.
    for (int j = 0; j < COL; j++) begin
      idle();
      bus.wr[j] = 1'b1;
      bus.in[lane_lo(j) +: BW_PSUM] = BW_PSUM'(j + 1);
      step();
      lit("stagger_valid", bus.o_valid, (j == COL - 1));
    end
    idle();
    for (int j = 0; j < COL; j++)
      check("stagger_lane", ROW_W'(bus.out[lane_lo(j) +: BW_PSUM]), ROW_W'(j + 1));
    lit("stagger_empty", bus.o_empty, 1'b0);
    bus.rd = 1'b1;
    step();
    idle();
    lit("pop_valid", bus.o_valid, 1'b0);
    lit("pop_empty", bus.o_empty, 1'b1);
    check("pop_out", bus.out, '0);

    // 16 staggered rows, lane j of row r = 16*r+j.
    for (int t = 0; t < DEPTH + COL - 1; t++) begin
      idle();
      for (int j = 0; j < COL; j++) begin
        int r;
        r = t - j;
        if (r >= 0 && r < DEPTH) begin
          bus.wr[j] = 1'b1;
          bus.in[lane_lo(j) +: BW_PSUM] = BW_PSUM'(16 * r + j);
        end
      end
      step();
    end
    idle();
    lit("fill_full", bus.o_full, 1'b1);
    lit("fill_ovf0", bus.o_overflow, 1'b0);
    bus.wr[0] = 1'b1;
    bus.in[lane_lo(0) +: BW_PSUM] = BW_PSUM'(999);
    step();
    idle();
    lit("drop_ovf", bus.o_overflow, 1'b1);
    for (int r = 0; r < DEPTH; r++) begin
      check("drain_lane7", ROW_W'(bus.out[lane_lo(COL-1) +: BW_PSUM]), ROW_W'(16 * r + COL - 1));
      check("drain_lane0", ROW_W'(bus.out[lane_lo(0) +: BW_PSUM]), ROW_W'(16 * r));
      bus.rd = 1'b1;
      step();
    end
    idle();
    lit("drain_empty", bus.o_empty, 1'b1);

    // Full lanes: write all + pop same cycle must not drop.
    do_reset();
    for (int r = 0; r < DEPTH; r++) begin
      bus.wr = '1;
      bus.in = rand_row();
      step();
    end
    bus.wr = '1;
    bus.in = rand_row();
    row = bus.in;
    bus.rd = 1'b1;
    step();
    idle();
    lit("wrpop_ovf",  bus.o_overflow, 1'b0);
    lit("wrpop_full", bus.o_full, 1'b1);
    for (int r = 0; r < DEPTH; r++) begin
      if (r == DEPTH - 1) check("wrpop_tail", bus.out, row);
      bus.rd = 1'b1;
      step();
    end
    idle();

    // rd while lane 7 is empty is ignored.
    do_reset();
    for (int j = 0; j < COL - 1; j++) begin
      bus.wr[j] = 1'b1;
      bus.in[lane_lo(j) +: BW_PSUM] = BW_PSUM'(100 + j);
    end
    step();
    idle();
    bus.rd = 1'b1;
    step();
    idle();
    lit("partial_valid", bus.o_valid, 1'b0);
    bus.wr[COL-1] = 1'b1;
    bus.in[lane_lo(COL-1) +: BW_PSUM] = BW_PSUM'(100 + COL - 1);
    step();
    idle();
    lit("partial_valid2", bus.o_valid, 1'b1);
    for (int j = 0; j < COL; j++)
      check("partial_lane", ROW_W'(bus.out[lane_lo(j) +: BW_PSUM]), ROW_W'(100 + j));

    // Reset mid-operation with traffic active.
    for (int r = 0; r < 4; r++) begin
      bus.wr = '1;
      bus.in = rand_row();
      step();
    end
    bus.wr = '1;
    bus.rd = 1'b1;
    bus.in = rand_row();
    reset = 1'b0;
    step();
    reset = 1'b1;
    idle();
    lit("midrst_empty", bus.o_empty, 1'b1);
    lit("midrst_valid", bus.o_valid, 1'b0);
    lit("midrst_ovf",   bus.o_overflow, 1'b0);
    for (int j = 0; j < COL; j++) bus.in[lane_lo(j) +: BW_PSUM] = BW_PSUM'(200 + j);
    bus.wr = '1;
    step();
    idle();
    for (int j = 0; j < COL; j++)
      check("postrst_lane", ROW_W'(bus.out[lane_lo(j) +: BW_PSUM]), ROW_W'(200 + j));
    bus.rd = 1'b1;
    step();
    idle();
    lit("postrst_empty", bus.o_empty, 1'b1);

    // Randomized traffic; regimes alternate between filling and draining.
    for (int c = 0; c < 3000; c++) begin
      int regime;
      regime = (c / 250) % 3;
      reset = ($urandom_range(0, 399) != 0);
      for (int j = 0; j < COL; j++) begin
        case (regime)
          0:       bus.wr[j] = ($urandom_range(0, 3) != 0);
          1:       bus.wr[j] = ($urandom_range(0, 3) == 0);
          default: bus.wr[j] = $urandom_range(0, 1) != 0;
        endcase
      end
      bus.in = rand_row();
      case (regime)
        0:       bus.rd = ($urandom_range(0, 5) == 0);
        1:       bus.rd = ($urandom_range(0, 3) != 0);
        default: bus.rd = $urandom_range(0, 1) != 0;
      endcase
      step();
    end
    reset = 1'b1;
    idle();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
